// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing a single alu32 between the EX issue path (port 0)
// and the branch/address unit (port 1); one operation in flight at a time.
//
// state | meaning
// IDLE  | waiting for a request; ready is offered to the granted requester
// EXEC  | operands held on alu_*; counting down the ALU latency
// RESP  | response held on rsp_* until the consumer takes it
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_data1,
    input  logic [WIDTH-1:0] r0_data2,
    input  logic [2:0]       r0_ctrl,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_data1,
    input  logic [WIDTH-1:0] r1_data2,
    input  logic [2:0]       r1_ctrl,

    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] op_data1_q;
    logic [WIDTH-1:0] op_data2_q;
    logic [2:0]       op_ctrl_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_out_q;
    logic             rsp_carry_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;

    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_data1;
    logic [WIDTH-1:0] sel_data2;
    logic [2:0]       sel_ctrl;
    logic             sel_legal;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_id = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_id = ~last_grant_q;
        end else if (r1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept    = (state_q == IDLE) && (r0_valid || r1_valid);
    assign r0_ready  = accept && !grant_id;
    assign r1_ready  = accept && grant_id;

    assign sel_data1 = grant_id ? r1_data1 : r0_data1;
    assign sel_data2 = grant_id ? r1_data2 : r0_data2;
    assign sel_ctrl  = grant_id ? r1_ctrl  : r0_ctrl;
    assign sel_legal = (sel_ctrl <= 3'b100);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            op_data1_q   <= '0;
            op_data2_q   <= '0;
            op_ctrl_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_grant_q <= grant_id;
                        rsp_id_q     <= grant_id;
                        if (sel_legal) begin
                            op_data1_q <= sel_data1;
                            op_data2_q <= sel_data2;
                            op_ctrl_q  <= sel_ctrl;
                            cnt_q      <= CNT_W'(ALU_LAT);
                            state_q    <= EXEC;
                        end else begin
                            // Illegal op never reaches the ALU; answer at once.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_out_q   <= '0;
                            rsp_carry_q <= 1'b0;
                            rsp_zero_q  <= 1'b0;
                            state_q     <= RESP;
                        end
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_out_q   <= alu_out;
                        rsp_carry_q <= alu_carry;
                        rsp_zero_q  <= alu_zero;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_data1 = op_data1_q;
    assign alu_data2 = op_data2_q;
    assign alu_ctrl  = op_ctrl_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule
